// File: rtl/branch_resolve_if.sv
// Bundles the branch request inputs, the ALU flags, the next-PC decision and the
// link-write handshake between the front end and branch_resolve_unit.
interface branch_resolve_if;
  logic        br_valid;
  logic [3:0]  br_op;
  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] reg_target;
  logic        zout;
  logic        statusZ;
  logic        statusN;
  logic        statusV;
  logic        link_ack;
  logic        pc_sel;
  logic [31:0] pc_next;
  logic        taken;
  logic        stall;
  logic        link_req;
  logic [4:0]  link_addr;
  logic [31:0] link_data;
  logic        link_err;
  logic        bad_op;

  modport master (
    output br_valid, br_op, pc_plus4, br_target, reg_target,
           zout, statusZ, statusN, statusV, link_ack,
    input  pc_sel, pc_next, taken, stall, link_req, link_addr,
           link_data, link_err, bad_op
  );

  modport slave (
    input  br_valid, br_op, pc_plus4, br_target, reg_target,
           zout, statusZ, statusN, statusV, link_ack,
    output pc_sel, pc_next, taken, stall, link_req, link_addr,
           link_data, link_err, bad_op
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves one branch per request, registers the next-PC decision and, for taken
// link branches, runs a bounded request/acknowledge write of the return address.
module branch_resolve_unit #(
  parameter logic [4:0] LINK_REG = 5'd31,
  parameter int         MAX_WAIT = 8
) (
  input  logic             clk,
  input  logic             reset,
  branch_resolve_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DECIDE, LINK} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state_reg, state_next;
  logic        pc_sel_reg;
  logic [31:0] pc_next_reg;
  logic        taken_reg;
  logic        bad_op_reg;
  logic        link_go_reg;
  logic [31:0] link_data_reg;
  logic        link_err_reg;
  logic [7:0]  wait_cnt_reg;

  logic accept;
  logic timeout;
  logic cond_taken, is_link, use_reg, is_branch, is_bad;

  assign accept  = (state_reg == IDLE) && bus.br_valid;
  assign timeout = (state_reg == LINK) && !bus.link_ack && (wait_cnt_reg == WAIT_LAST);

  // Opcode decode works on the live inputs so the decision is ready at the accept edge.
  always_comb begin
    cond_taken = 1'b0;
    is_link    = 1'b0;
    use_reg    = 1'b0;
    is_branch  = 1'b1;
    is_bad     = 1'b0;
    case (bus.br_op)
      4'b0000: is_branch = 1'b0;
      4'b0001: cond_taken = bus.zout;
      4'b0010: cond_taken = ~bus.zout;
      4'b0011: cond_taken = bus.statusZ;
      4'b0100: cond_taken = bus.statusN;
      4'b0101: cond_taken = bus.statusV;
      4'b0110: begin
        cond_taken = bus.statusZ | bus.statusN;
        is_link    = 1'b1;
      end
      4'b0111: begin
        cond_taken = 1'b1;
        is_link    = 1'b1;
      end
      4'b1000: begin
        cond_taken = 1'b1;
        use_reg    = 1'b1;
      end
      4'b1001: begin
        cond_taken = 1'b1;
        use_reg    = 1'b1;
        is_link    = 1'b1;
      end
      default: begin
        is_branch = 1'b0;
        is_bad    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.br_valid) state_next = DECIDE;
      DECIDE:  state_next = link_go_reg ? LINK : IDLE;
      LINK:    if (bus.link_ack || timeout) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_sel_reg    <= 1'b0;
      pc_next_reg   <= '0;
      taken_reg     <= 1'b0;
      bad_op_reg    <= 1'b0;
      link_go_reg   <= 1'b0;
      link_data_reg <= '0;
      link_err_reg  <= 1'b0;
      wait_cnt_reg  <= '0;
    end else begin
      pc_sel_reg <= 1'b0;
      bad_op_reg <= 1'b0;
      if (accept) begin
        pc_sel_reg    <= is_branch;
        bad_op_reg    <= is_bad;
        taken_reg     <= is_branch && cond_taken;
        link_go_reg   <= is_branch && cond_taken && is_link;
        link_data_reg <= bus.pc_plus4;
        // A nop or bad opcode is not a decision, so the previous target is kept.
        if (is_branch) begin
          if (!cond_taken)  pc_next_reg <= bus.pc_plus4;
          else if (use_reg) pc_next_reg <= bus.reg_target;
          else              pc_next_reg <= bus.br_target;
        end
      end
      if (state_reg == LINK && !bus.link_ack) wait_cnt_reg <= wait_cnt_reg + 8'd1;
      else                                    wait_cnt_reg <= '0;
      if (timeout) link_err_reg <= 1'b1;
    end
  end

  assign bus.pc_sel    = pc_sel_reg;
  assign bus.pc_next   = pc_next_reg;
  assign bus.taken     = taken_reg;
  assign bus.bad_op    = bad_op_reg;
  assign bus.stall     = (state_reg != IDLE);
  assign bus.link_req  = (state_reg == LINK);
  assign bus.link_addr = (state_reg == LINK) ? LINK_REG : 5'd0;
  assign bus.link_data = link_data_reg;
  assign bus.link_err  = link_err_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: inputs change and outputs are checked on
// the falling edge, expected values are hand-computed constants.
module tb_branch_resolve_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  branch_resolve_if bus ();

  branch_resolve_unit #(.LINK_REG(5'd31), .MAX_WAIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents one request at the current falling edge; returns at the falling edge of DECIDE.
  task automatic issue(input logic [3:0] op, input logic [31:0] pc4, input logic [31:0] bt,
                       input logic [31:0] rt, input logic z, input logic fz, input logic fn,
                       input logic fv);
    bus.br_op      = op;
    bus.pc_plus4   = pc4;
    bus.br_target  = bt;
    bus.reg_target = rt;
    bus.zout       = z;
    bus.statusZ    = fz;
    bus.statusN    = fn;
    bus.statusV    = fv;
    bus.br_valid   = 1'b1;
    @(negedge clk);
    bus.br_valid   = 1'b0;
    $display("txn op=%h pc_plus4=%h pc_sel=%0d pc_next=%h taken=%0d bad_op=%0d",
             op, pc4, bus.pc_sel, bus.pc_next, bus.taken, bus.bad_op);
  endtask

  initial begin
    reset          = 1'b1;
    bus.br_valid   = 1'b0;
    bus.br_op      = 4'h0;
    bus.pc_plus4   = '0;
    bus.br_target  = '0;
    bus.reg_target = '0;
    bus.zout       = 1'b0;
    bus.statusZ    = 1'b0;
    bus.statusN    = 1'b0;
    bus.statusV    = 1'b0;
    bus.link_ack   = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_pc_sel", 32'(bus.pc_sel), 32'd0);
    chk("rst_pc_next", bus.pc_next, 32'd0);
    chk("rst_taken", 32'(bus.taken), 32'd0);
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_link_req", 32'(bus.link_req), 32'd0);
    chk("rst_link_addr", 32'(bus.link_addr), 32'd0);
    chk("rst_link_data", bus.link_data, 32'd0);
    chk("rst_link_err", 32'(bus.link_err), 32'd0);
    chk("rst_bad_op", 32'(bus.bad_op), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_pc_sel", 32'(bus.pc_sel), 32'd0);
    end

    // beq taken then not taken
    issue(4'h1, 32'h10, 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("beq_t_pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("beq_t_pc_next", bus.pc_next, 32'h40);
    chk("beq_t_taken", 32'(bus.taken), 32'd1);
    chk("beq_t_stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    chk("beq_t_pulse_end", 32'(bus.pc_sel), 32'd0);
    chk("beq_t_idle", 32'(bus.stall), 32'd0);
    chk("beq_t_hold", bus.pc_next, 32'h40);
    issue(4'h1, 32'h10, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("beq_n_pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("beq_n_pc_next", bus.pc_next, 32'h10);
    chk("beq_n_taken", 32'(bus.taken), 32'd0);
    @(negedge clk);

    // blezal taken on N, ack on the third LINK cycle
    issue(4'h6, 32'h100, 32'h200, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("blezal_pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("blezal_pc_next", bus.pc_next, 32'h200);
    chk("blezal_taken", 32'(bus.taken), 32'd1);
    chk("blezal_no_req_yet", 32'(bus.link_req), 32'd0);
    @(negedge clk);
    chk("blezal_req", 32'(bus.link_req), 32'd1);
    chk("blezal_addr", 32'(bus.link_addr), 32'd31);
    chk("blezal_data", bus.link_data, 32'h100);
    chk("blezal_stall", 32'(bus.stall), 32'd1);
    chk("blezal_pulse_end", 32'(bus.pc_sel), 32'd0);
    @(negedge clk);
    chk("blezal_req2", 32'(bus.link_req), 32'd1);
    @(negedge clk);
    chk("blezal_req3", 32'(bus.link_req), 32'd1);
    bus.link_ack = 1'b1;
    @(negedge clk);
    bus.link_ack = 1'b0;
    chk("blezal_ack_req", 32'(bus.link_req), 32'd0);
    chk("blezal_ack_stall", 32'(bus.stall), 32'd0);
    chk("blezal_ack_addr", 32'(bus.link_addr), 32'd0);
    chk("blezal_ack_err", 32'(bus.link_err), 32'd0);

    // blezal not taken
    issue(4'h6, 32'h100, 32'h200, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("blezal_n_pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("blezal_n_pc_next", bus.pc_next, 32'h100);
    chk("blezal_n_taken", 32'(bus.taken), 32'd0);
    @(negedge clk);
    chk("blezal_n_req", 32'(bus.link_req), 32'd0);
    chk("blezal_n_stall", 32'(bus.stall), 32'd0);

    // jmxor with no ack: link_req high exactly 8 cycles then link_err
    issue(4'h9, 32'h300, 32'h0, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("jmxor_pc_next", bus.pc_next, 32'h1234);
    chk("jmxor_taken", 32'(bus.taken), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("jmxor_req_high", 32'(bus.link_req), 32'd1);
      chk("jmxor_err_low", 32'(bus.link_err), 32'd0);
    end
    @(negedge clk);
    chk("jmxor_req_drop", 32'(bus.link_req), 32'd0);
    chk("jmxor_err_set", 32'(bus.link_err), 32'd1);
    chk("jmxor_stall_drop", 32'(bus.stall), 32'd0);
    issue(4'h2, 32'h304, 32'h500, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bne_pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("bne_pc_next", bus.pc_next, 32'h500);
    chk("bne_taken", 32'(bus.taken), 32'd1);
    chk("err_sticky", 32'(bus.link_err), 32'd1);
    @(negedge clk);

    // back-to-back: br_valid held across a jal, ack in the first LINK cycle
    bus.br_op     = 4'h7;
    bus.pc_plus4  = 32'h400;
    bus.br_target = 32'h600;
    bus.br_valid  = 1'b1;
    @(negedge clk);
    chk("jal_pc_next", bus.pc_next, 32'h600);
    chk("jal_pc_sel", 32'(bus.pc_sel), 32'd1);
    bus.br_op     = 4'h1;
    bus.pc_plus4  = 32'h404;
    bus.br_target = 32'h700;
    bus.zout      = 1'b1;
    bus.statusZ   = 1'b1;
    bus.statusN   = 1'b1;
    bus.statusV   = 1'b1;
    @(negedge clk);
    chk("b2b_link_req", 32'(bus.link_req), 32'd1);
    chk("b2b_link_data", bus.link_data, 32'h400);
    chk("b2b_no_accept", 32'(bus.pc_sel), 32'd0);
    chk("b2b_pc_next_held", bus.pc_next, 32'h600);
    bus.link_ack = 1'b1;
    @(negedge clk);
    bus.link_ack = 1'b0;
    chk("b2b_ack0_req", 32'(bus.link_req), 32'd0);
    chk("b2b_ack0_stall", 32'(bus.stall), 32'd0);
    chk("b2b_ack0_pc_sel", 32'(bus.pc_sel), 32'd0);
    @(negedge clk);
    bus.br_valid = 1'b0;
    chk("b2b_second_pc_sel", 32'(bus.pc_sel), 32'd1);
    chk("b2b_second_pc_next", bus.pc_next, 32'h700);
    @(negedge clk);

    // unsupported opcode
    issue(4'hC, 32'h800, 32'h900, 32'h0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("bad_pulse", 32'(bus.bad_op), 32'd1);
    chk("bad_no_pc_sel", 32'(bus.pc_sel), 32'd0);
    chk("bad_no_req", 32'(bus.link_req), 32'd0);
    @(negedge clk);
    chk("bad_pulse_end", 32'(bus.bad_op), 32'd0);
    chk("bad_no_req2", 32'(bus.link_req), 32'd0);

    // reset asserted mid-cycle while in LINK
    issue(4'h7, 32'hA00, 32'hB00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rstlink_req_before", 32'(bus.link_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("rstlink_req", 32'(bus.link_req), 32'd0);
    chk("rstlink_stall", 32'(bus.stall), 32'd0);
    chk("rstlink_err", 32'(bus.link_err), 32'd0);
    chk("rstlink_pc_next", bus.pc_next, 32'd0);
    chk("rstlink_data", bus.link_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstlink_idle_pc_sel", 32'(bus.pc_sel), 32'd0);
      chk("rstlink_idle_req", 32'(bus.link_req), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
